instr_prefetch_queue: RTL

INSTR_PREFETCH_QUEUE -- requirements
Module: instr_prefetch_queue

---
 rtl/instr_prefetch_queue_pkg.sv | 18 +
 rtl/instr_prefetch_queue_fifo.sv | 54 +++++
 rtl/instr_prefetch_queue.sv | 121 ++++++++++++
 3 files changed

// File: rtl/instr_prefetch_queue_pkg.sv
// Shared types and defaults for the instruction prefetch queue.
// Holds the FSM encoding and the queue entry layout.
package instr_prefetch_queue_pkg;

  localparam int unsigned DEPTH_DEF    = 4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

endpackage

// File: rtl/instr_prefetch_queue_fifo.sv
// Circular buffer of fetched {instr, pc} entries.
// Occupancy is tracked by the owner; this block only moves pointers.
module prefetch_fifo
  import instr_prefetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push_i,
  input  logic   pop_i,
  input  logic   flush_i,
  input  entry_t wdata_i,
  output entry_t rdata_o
);

  localparam int PW = $clog2(DEPTH);

  entry_t         mem_q [DEPTH];
  logic [PW-1:0]  head_q, head_d;
  logic [PW-1:0]  tail_q, tail_d;

  // next pointer values; flush empties the buffer
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (flush_i) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      if (pop_i)  head_d = head_q + PW'(1);
      if (push_i) tail_d = tail_q + PW'(1);
    end
  end

  // pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // entry storage, written at the tail
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[tail_q] <= wdata_i;
  end

  assign rdata_o = mem_q[head_q];

endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: issues in-order fetches, buffers
// responses, and drains stale responses after a redirect.
module instr_prefetch_queue
  import instr_prefetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready
);

  localparam int CW = $clog2(DEPTH) + 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_e         state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic [CW-1:0]  inflight_q, inflight_d;
  logic [CW-1:0]  drop_q, drop_d;
  logic [31:0]    fetch_pc_q, fetch_pc_d;
  logic [31:0]    resp_pc_q, resp_pc_d;
  logic           mem_req_q, mem_req_d;

  logic   transfer, push, pop, ret;
  entry_t wentry, head;

  assign transfer = mem_req_q & mem_gnt;
  assign ret      = mem_rvalid & (state_q == FETCH);
  assign push     = ret & ~redirect;
  assign pop      = (count_q != '0) & if_ready & ~redirect;

  assign wentry.instr = mem_rdata;
  assign wentry.pc    = resp_pc_q;

  prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect),
    .wdata_i (wentry),
    .rdata_o (head)
  );

  // next-state logic; redirect overrides every other event
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    if (redirect) begin
      count_d    = '0;
      inflight_d = '0;
      drop_d     = drop_q + inflight_q
                 + CW'(transfer) - CW'(mem_rvalid);
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      resp_pc_d  = {redirect_pc[31:2], 2'b00};
      state_d    = (drop_d != '0) ? DRAIN : FETCH;
    end else begin
      if (transfer) fetch_pc_d = fetch_pc_q + 32'd4;
      unique case (state_q)
        FETCH: begin
          count_d    = count_q + CW'(push) - CW'(pop);
          inflight_d = inflight_q + CW'(transfer)
                     - CW'(ret);
          if (push) resp_pc_d = resp_pc_q + 32'd4;
        end
        DRAIN: begin
          if (mem_rvalid) begin
            drop_d = drop_q - CW'(1);
            if (drop_q == CW'(1)) state_d = FETCH;
          end
        end
      endcase
    end
    mem_req_d = ~redirect & (state_d == FETCH)
              & ((count_d + inflight_d) < DEPTH_C);
  end

  // state, counters and registered request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= FETCH;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      mem_req_q  <= 1'b0;
    end else begin
      assert (!(push && count_q == DEPTH_C && !pop));
      state_q    <= state_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      mem_req_q  <= mem_req_d;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = fetch_pc_q;
  assign if_valid = (count_q != '0);
  assign if_instr = head.instr;
  assign if_pc    = head.pc;

endmodule
